// File: rtl/synchronous_4bit_up_down_counter_struct.sv
// Synchronous 4-bit up/down counter built from four T flip-flops on a common clock.
// Optional terminal-count output tc is enabled by defining COUNTER_TC_EN.

module t_flip_flop (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

module synchronous_4bit_up_down_counter_struct (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t,
    input  logic       mode,
    output logic [3:0] qout
`ifdef COUNTER_TC_EN
    ,
    output logic       tc
`endif
);

    logic [3:0] q_bits;
    logic [3:0] up_chain;
    logic [3:0] down_chain;
    logic [3:0] toggle_en;

    // Bit i toggles once every lower bit is all-ones (up) or all-zeros (down).
    assign up_chain[0]   = t;
    assign down_chain[0] = t;

    genvar i;
    generate
        for (i = 1; i < 4; i++) begin : g_chain
            assign up_chain[i]   = up_chain[i-1] & q_bits[i-1];
            assign down_chain[i] = down_chain[i-1] & ~q_bits[i-1];
        end

        for (i = 0; i < 4; i++) begin : g_tff
            assign toggle_en[i] = mode ? down_chain[i] : up_chain[i];

            t_flip_flop u_tff (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (toggle_en[i]),
                .q     (q_bits[i])
            );
        end
    endgenerate

    assign qout = q_bits;

`ifdef COUNTER_TC_EN
    // High on the cycle whose next enabled edge wraps the counter.
    assign tc = t & ((~mode & (q_bits == 4'd15)) | (mode & (q_bits == 4'd0)));
`endif

endmodule

// File: tb/tb_synchronous_4bit_up_down_counter_struct.sv
// Self-checking bench for synchronous_4bit_up_down_counter_struct: directed steps plus
// randomized t/mode/reset checked against an arithmetic mod-16 model.

module tb_synchronous_4bit_up_down_counter_struct;

    logic       clk;
    logic       rst_n;
    logic       t;
    logic       mode;
    logic [3:0] qout;
`ifdef COUNTER_TC_EN
    logic       tc;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q = 0;

    synchronous_4bit_up_down_counter_struct dut (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .mode  (mode)
`ifdef COUNTER_TC_EN
        ,
        .tc    (tc)
`endif
        ,
        .qout  (qout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs at the falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic apply_stimulus(input logic t_v, input logic mode_v);
        t    = t_v;
        mode = mode_v;
        @(posedge clk);
        if (!rst_n)
            exp_q = 0;
        else if (t)
            exp_q = mode ? (exp_q + 15) % 16 : (exp_q + 1) % 16;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag);
        total++;
        assert (qout === 4'(exp_q))
        else begin
            bad++;
            $error("[TB] FAIL %s qout=%0d expected=%0d", tag, qout, exp_q);
        end
`ifdef COUNTER_TC_EN
        begin
            logic exp_tc;
            exp_tc = t && ((!mode && exp_q == 15) || (mode && exp_q == 0));
            total++;
            assert (tc === exp_tc)
            else begin
                bad++;
                $error("[TB] FAIL %s_tc tc=%0b expected=%0b", tag, tc, exp_tc);
            end
        end
`endif
    endtask

    task automatic step_check(input logic t_v, input logic mode_v, input string tag);
        apply_stimulus(t_v, mode_v);
        check_output(tag);
    endtask

    // Pull reset low between edges and confirm qout clears with no clock edge.
    task automatic async_reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        exp_q = 0;
        #1 check_output({tag, "_immediate"});
        apply_stimulus(1'b1, 1'b0);
        check_output({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        t     = 1'b1;
        mode  = 1'b0;
        exp_q = 0;

        #1 check_output("reset_t1");
        @(negedge clk);
        check_output("reset_t10");
        @(negedge clk);
        check_output("reset_t20");
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++)
            step_check(1'b1, 1'b0, "release_count");

        for (int i = 0; i < 16; i++)
            step_check(1'b1, 1'b0, "up_wrap");

        while (exp_q != 10)
            step_check(1'b1, 1'b0, "up_to_10");

        for (int i = 0; i < 12; i++)
            step_check(1'b1, 1'b1, "down_wrap");

        while (exp_q != 6)
            step_check(1'b1, 1'b1, "down_to_6");

        for (int i = 0; i < 5; i++)
            step_check(1'b0, 1'(i % 2), "hold_6");
        step_check(1'b1, 1'b0, "resume_7");

        while (exp_q != 12)
            step_check(1'b1, 1'b0, "up_to_12");
        async_reset_pulse("mid_reset");

        while (exp_q != 5)
            step_check(1'b1, 1'b0, "up_to_5");
        for (int i = 0; i < 4; i++)
            step_check(1'b1, 1'(i % 2), "mode_toggle");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 31) == 0)
                async_reset_pulse("rand_reset");
            else
                step_check(1'($urandom), 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synchronous_4bit_up_down_counter_struct.md
SYNCHRONOUS_4BIT_UP_DOWN_COUNTER_STRUCT -- requirements
Module: synchronous_4bit_up_down_counter_struct

Interface
- Parameters: none; width is fixed at 4 bits.
- REQ-001 clk  input  1  single clock; all state changes on the rising edge, except reset.
- REQ-002 rst_n  input  1  reset, asynchronous, active-low.
- REQ-003 t  input  1  count enable (global toggle input); 1 = count, 0 = hold.
- REQ-004 mode  input  1  direction; 0 = up, 1 = down.
- REQ-005 qout  output  4  counter value, unsigned; qout[0] is the LSB.
- REQ-006 tc  output  1  terminal-count flag; present only when COUNTER_TC_EN is defined (see Configuration).

Function
- REQ-007 Structure SHALL be four T flip-flops sharing clk and rst_n (synchronous counter); no ripple clocking.
- REQ-008 Toggle enable of bit 0 SHALL be t.
- REQ-009 Up mode: bit i (i>0) SHALL toggle when t=1 and qout[i-1:0] are all 1.
- REQ-010 Down mode: bit i (i>0) SHALL toggle when t=1 and qout[i-1:0] are all 0.
- REQ-011 Net effect per rising edge when t=1:
  - mode=0 → qout = qout+1 mod 16
  - mode=1 → qout = qout-1 mod 16
- REQ-012 When t=0, qout SHALL hold its value on every edge, regardless of mode.
- REQ-013 Wrap-around: up from 15 SHALL give 0; down from 0 SHALL give 15; no saturation, no flag except tc.
- REQ-014 mode and t SHALL be sampled at the rising edge; a change between edges SHALL affect only the next edge, with no glitch on qout.
- REQ-015 Latency: qout SHALL update one clk-to-q delay after the sampling edge; there SHALL be no pipeline.
- REQ-016 There SHALL be no handshake; the counter advances on every enabled edge.

Reset
- REQ-017 While rst_n=0, qout SHALL be 4'b0000 immediately, independent of clk, t and mode.
- REQ-018 tc SHALL be 0 during reset when mode=0, and SHALL follow REQ-021 otherwise.
- REQ-019 Reset asserted mid-count SHALL override any pending toggle.
- REQ-020 First count SHALL occur on the first rising edge with rst_n=1 and t=1: 0→1 in up mode, 0→15 in down mode.

Configuration
- REQ-021 Macro COUNTER_TC_EN defined:
  - Port tc SHALL exist.
  - tc = t & ((~mode & qout==15) | (mode & qout==0)), combinational.
  - tc therefore marks the edge on which the counter wraps.
- REQ-022 Macro COUNTER_TC_EN undefined: port tc and its logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-023 rst_n=0 for 20 ns with t=1, mode=0 → qout=0 throughout; release → qout 1,2,3,… on successive edges (10 ns period).
- REQ-024 Up count from 0 with t=1 for 16 edges → sequence 0..15 then 0 (wrap); with COUNTER_TC_EN, tc=1 only while qout=15.
- REQ-025 After up-counting to 10, set mode=1 → 9,8,…,0,15,14 (wrap down); with COUNTER_TC_EN, tc=1 only while qout=0.
- REQ-026 t=0 for 5 edges at qout=6, toggling mode meanwhile → qout stays 6; then t=1, mode=0 → 7 on the next edge.
- REQ-027 Assert rst_n=0 between edges at qout=12 → qout=0 immediately, with no clk edge needed; holds at 0 until release.
- REQ-028 Toggle mode every edge from qout=5 with t=1 → 6,5,6,5 (up, down, up, down), confirming edge sampling.
